// File: rtl/mem_port_arbiter.sv
// Shares the off-chip memory read/write ports between the I-cache and D-cache.
// Round-robin grant, atomic write-back-then-refill, routed acks, stuck-memory timeout.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no owner; grant a pending requester (tie -> not served last)
// WRITE  | owner's write-back on port 2, waiting for write_ack
// READ   | owner's refill on port 1, waiting for read_ack
// DONE   | dead cycle with no grant; remember who was served

module mem_port_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 i_rd_req,
   input  logic                 d_rd_req,
   input  logic                 i_wr_req,
   input  logic                 d_wr_req,
   input  logic [WORD_SIZE-1:0] i_rd_addr,
   input  logic [WORD_SIZE-1:0] i_wr_addr,
   input  logic [WORD_SIZE-1:0] d_rd_addr,
   input  logic [WORD_SIZE-1:0] d_wr_addr,
   input  logic [63:0]          i_wr_line,
   input  logic [63:0]          d_wr_line,
   output logic                 i_rd_ack,
   output logic                 i_wr_ack,
   output logic                 d_rd_ack,
   output logic                 d_wr_ack,
   output logic [63:0]          rd_line,
   output logic                 readM1,
   output logic [WORD_SIZE-1:0] address1,
   output logic                 writeM2,
   output logic [WORD_SIZE-1:0] address2,
   output logic [63:0]          data2,
   input  logic [63:0]          data1,
   input  logic                 read_ack,
   input  logic                 write_ack,
   output logic [1:0]           owner,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_I     = 2'b01;
   localparam logic [1:0] OWN_D     = 2'b10;
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   state_t               state_q;
   state_t               state_nxt;
   logic [1:0]           owner_q;
   logic                 last_d_q;
   logic                 rd_flag_q;
   logic [WORD_SIZE-1:0] rd_addr_q;
   logic [WORD_SIZE-1:0] wr_addr_q;
   logic [63:0]          wr_line_q;
   logic [7:0]           tmo_cnt_q;
   logic                 timeout_err_q;

   logic                 i_pend;
   logic                 d_pend;
   logic                 grant_any;
   logic                 grant_d;
   logic                 grant_wr;
   logic                 tmo_hit;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      i_pend    = i_rd_req | i_wr_req;
      d_pend    = d_rd_req | d_wr_req;
      grant_any = i_pend | d_pend;
      grant_d   = d_pend & (~i_pend | ~last_d_q);
      grant_wr  = grant_d ? d_wr_req : i_wr_req;
      tmo_hit   = (tmo_cnt_q == TMO_LIMIT);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               state_nxt = grant_wr ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            if (write_ack) begin
               state_nxt = rd_flag_q ? ST_READ : ST_DONE;
            end else if (tmo_hit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_READ: begin
            if (read_ack || tmo_hit) begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request lines are only looked at on grant; the latched copy drives the transfer.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         owner_q       <= OWN_NONE;
         last_d_q      <= 1'b1;
         rd_flag_q     <= 1'b0;
         rd_addr_q     <= '0;
         wr_addr_q     <= '0;
         wr_line_q     <= '0;
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_any) begin
                  owner_q   <= grant_d ? OWN_D : OWN_I;
                  rd_flag_q <= grant_d ? d_rd_req : i_rd_req;
                  rd_addr_q <= grant_d ? d_rd_addr : i_rd_addr;
                  wr_addr_q <= grant_d ? d_wr_addr : i_wr_addr;
                  wr_line_q <= grant_d ? d_wr_line : i_wr_line;
                  tmo_cnt_q <= '0;
               end
            end
            ST_WRITE: begin
               if (write_ack) begin
                  tmo_cnt_q <= '0;
               end else if (tmo_hit) begin
                  timeout_err_q <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end
            ST_READ: begin
               if (!read_ack) begin
                  if (tmo_hit) begin
                     timeout_err_q <= 1'b1;
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + 8'd1;
                  end
               end
            end
            default: begin
               last_d_q <= (owner_q == OWN_D);
               owner_q  <= OWN_NONE;
            end
         endcase
      end
   end

   // Acks are the raw memory acks, qualified by phase and owner.
   always_comb begin
      readM1   = 1'b0;
      writeM2  = 1'b0;
      address1 = '0;
      address2 = '0;
      data2    = '0;
      owner    = OWN_NONE;
      i_rd_ack = 1'b0;
      i_wr_ack = 1'b0;
      d_rd_ack = 1'b0;
      d_wr_ack = 1'b0;
      case (state_q)
         ST_WRITE: begin
            writeM2  = 1'b1;
            address2 = wr_addr_q;
            data2    = wr_line_q;
            owner    = owner_q;
            i_wr_ack = write_ack & (owner_q == OWN_I);
            d_wr_ack = write_ack & (owner_q == OWN_D);
         end
         ST_READ: begin
            readM1   = 1'b1;
            address1 = rd_addr_q;
            owner    = owner_q;
            i_rd_ack = read_ack & (owner_q == OWN_I);
            d_rd_ack = read_ack & (owner_q == OWN_D);
         end
         default: begin
         end
      endcase
   end

   assign rd_line     = data1;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then random cache/memory agents checked against a transaction-level reference model.

module tb_mem_port_arbiter;

   localparam logic [63:0] C_DATA1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] C_DLINE = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] C_ILINE = 64'h5555_5555_5555_5555;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        i_rd_req, d_rd_req, i_wr_req, d_wr_req;
   logic [15:0] i_rd_addr, i_wr_addr, d_rd_addr, d_wr_addr;
   logic [63:0] i_wr_line, d_wr_line;
   logic        i_rd_ack, i_wr_ack, d_rd_ack, d_wr_ack;
   logic [63:0] rd_line;
   logic        readM1;
   logic [15:0] address1;
   logic        writeM2;
   logic [15:0] address2;
   logic [63:0] data2;
   logic [63:0] data1;
   logic        read_ack, write_ack;
   logic [1:0]  owner;
   logic        timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [5:0]  stim;   // {i_rd, i_wr, d_rd, d_wr, read_ack, write_ack}
      logic        rdm;
      logic        wrm;
      logic [1:0]  own;
      logic [3:0]  acks;   // {i_rd_ack, i_wr_ack, d_rd_ack, d_wr_ack}
      logic [15:0] a1;
   } vec_t;
   vec_t vecs[$];

   // reference model and agent state for the random phase
   int          m_ph, m_ph_prev, m_g, m_last, m_wait;
   logic        m_err, m_rdf;
   logic [15:0] m_ra, m_wa;
   logic [63:0] m_line;
   logic        p_rd[2], p_wr[2], p_rack, p_wack;
   logic [15:0] p_ra[2], p_wa[2];
   logic [63:0] p_line[2];
   logic        a_rd[2], a_wr[2];
   logic [15:0] a_ra[2], a_wa[2];
   logic [63:0] a_line[2];
   int          a_gap[2];
   int          mem_cnt, mem_lat;
   int          tmo_cycles, tmo_acks;
   logic [3:0]  e_acks;
   logic [1:0]  new_flags;

   always #5 Clk = ~Clk;

   mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT(255)) dut (
      .Clk(Clk), .Reset(Reset),
      .i_rd_req(i_rd_req), .d_rd_req(d_rd_req), .i_wr_req(i_wr_req), .d_wr_req(d_wr_req),
      .i_rd_addr(i_rd_addr), .i_wr_addr(i_wr_addr), .d_rd_addr(d_rd_addr), .d_wr_addr(d_wr_addr),
      .i_wr_line(i_wr_line), .d_wr_line(d_wr_line),
      .i_rd_ack(i_rd_ack), .i_wr_ack(i_wr_ack), .d_rd_ack(d_rd_ack), .d_wr_ack(d_wr_ack),
      .rd_line(rd_line), .readM1(readM1), .address1(address1),
      .writeM2(writeM2), .address2(address2), .data2(data2),
      .data1(data1), .read_ack(read_ack), .write_ack(write_ack),
      .owner(owner), .timeout_err(timeout_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic step(input logic [5:0] s);
      {i_rd_req, i_wr_req, d_rd_req, d_wr_req, read_ack, write_ack} = s;
      #1;
   endtask

   function automatic logic [3:0] acks_now();
      return {i_rd_ack, i_wr_ack, d_rd_ack, d_wr_ack};
   endfunction

   task automatic chk_state(input string tag, input logic rdm, input logic wrm,
                            input logic [1:0] own, input logic [3:0] acks);
      chk({tag, ".readM1"},  64'(readM1),     64'(rdm));
      chk({tag, ".writeM2"}, 64'(writeM2),    64'(wrm));
      chk({tag, ".owner"},   64'(owner),      64'(own));
      chk({tag, ".acks"},    64'(acks_now()), 64'(acks));
   endtask

   task automatic add_vec(input logic [5:0] s, input logic rdm, input logic wrm,
                          input logic [1:0] own, input logic [3:0] acks, input logic [15:0] a1);
      vec_t v;
      v.stim = s; v.rdm = rdm; v.wrm = wrm; v.own = own; v.acks = acks; v.a1 = a1;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      // I: rd 0x0010, wr 0x0020; D: rd 0x0080, wr 0x0040
      add_vec(6'b000000, 0, 0, 2'b00, 4'b0000, 16'h0000);
      add_vec(6'b101010, 0, 0, 2'b00, 4'b0000, 16'h0000);   // tie, spurious read_ack in IDLE
      add_vec(6'b101000, 1, 0, 2'b01, 4'b0000, 16'h0010);   // first tie -> I
      add_vec(6'b101001, 1, 0, 2'b01, 4'b0000, 16'h0010);   // write_ack during READ ignored
      add_vec(6'b101010, 1, 0, 2'b01, 4'b1000, 16'h0010);
      add_vec(6'b001000, 0, 0, 2'b00, 4'b0000, 16'h0000);   // DONE
      add_vec(6'b101000, 0, 0, 2'b00, 4'b0000, 16'h0000);   // IDLE, tie again
      add_vec(6'b101000, 1, 0, 2'b10, 4'b0000, 16'h0080);   // second tie -> D
      add_vec(6'b101010, 1, 0, 2'b10, 4'b0010, 16'h0080);
      add_vec(6'b100000, 0, 0, 2'b00, 4'b0000, 16'h0000);
      add_vec(6'b101000, 0, 0, 2'b00, 4'b0000, 16'h0000);
      add_vec(6'b101010, 1, 0, 2'b01, 4'b1000, 16'h0010);   // third tie -> I, zero-latency ack
      add_vec(6'b001000, 0, 0, 2'b00, 4'b0000, 16'h0000);   // req seen only in DONE
      add_vec(6'b000000, 0, 0, 2'b00, 4'b0000, 16'h0000);
      add_vec(6'b000000, 0, 0, 2'b00, 4'b0000, 16'h0000);   // ...so no grant

      Reset = 1'b1;
      {i_rd_req, i_wr_req, d_rd_req, d_wr_req, read_ack, write_ack} = '0;
      i_rd_addr = 16'h0010; i_wr_addr = 16'h0020;
      d_rd_addr = 16'h0080; d_wr_addr = 16'h0040;
      i_wr_line = C_ILINE;  d_wr_line = C_DLINE;
      data1 = C_DATA1;
      cyc();
      cyc();
      Reset = 1'b0;
      #1;
      chk_state("reset", 0, 0, 2'b00, 4'b0000);
      chk("reset.address1", 64'(address1), 64'h0);
      chk("reset.address2", 64'(address2), 64'h0);
      chk("reset.data2", data2, 64'h0);
      chk("reset.timeout_err", 64'(timeout_err), 64'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].stim);
         chk_state($sformatf("vec%0d", i), vecs[i].rdm, vecs[i].wrm, vecs[i].own, vecs[i].acks);
         chk($sformatf("vec%0d.address1", i), 64'(address1), 64'(vecs[i].a1));
         if (vecs[i].acks[3] || vecs[i].acks[1])
            chk($sformatf("vec%0d.rd_line", i), rd_line, C_DATA1);
         cyc();
      end

      // D write-back + refill with I pending throughout; last served was I
      step(6'b101100); chk_state("wbr.idle", 0, 0, 2'b00, 4'b0000); cyc();
      step(6'b101100); chk_state("wbr.wr", 0, 1, 2'b10, 4'b0000);
      chk("wbr.address2", 64'(address2), 64'h0040);
      chk("wbr.data2", data2, C_DLINE); cyc();
      step(6'b101101); chk_state("wbr.wack", 0, 1, 2'b10, 4'b0001); cyc();
      step(6'b101000); chk_state("wbr.rd", 1, 0, 2'b10, 4'b0000);
      chk("wbr.address1", 64'(address1), 64'h0080);
      chk("wbr.data2_idle", data2, 64'h0); cyc();
      step(6'b101010); chk_state("wbr.rack", 1, 0, 2'b10, 4'b0010); cyc();
      step(6'b100000); chk_state("wbr.done", 0, 0, 2'b00, 4'b0000); cyc();
      step(6'b100000); chk_state("wbr.idle2", 0, 0, 2'b00, 4'b0000); cyc();
      // I refill, memory answers three cycles after the read starts
      step(6'b100000); chk_state("irf.rd0", 1, 0, 2'b01, 4'b0000);
      chk("irf.address1", 64'(address1), 64'h0010); cyc();
      step(6'b000000); chk_state("irf.rd1", 1, 0, 2'b01, 4'b0000); cyc();
      step(6'b000000); chk_state("irf.rd2", 1, 0, 2'b01, 4'b0000); cyc();
      step(6'b000010); chk_state("irf.rack", 1, 0, 2'b01, 4'b1000);
      chk("irf.rd_line", rd_line, C_DATA1); cyc();
      step(6'b000000); chk_state("irf.done", 0, 0, 2'b00, 4'b0000); cyc();

      // stuck memory on a read
      step(6'b100000); chk("tmo.pre_err", 64'(timeout_err), 64'h0); cyc();
      tmo_cycles = 0;
      tmo_acks = 0;
      for (int k = 0; k < 300; k++) begin
         step(6'b000000);
         if (!readM1) break;
         tmo_cycles++;
         if (acks_now() != 4'b0000) tmo_acks++;
         if (k == 200) chk("tmo.err_early", 64'(timeout_err), 64'h0);
         cyc();
      end
      n_checks++;
      if (tmo_cycles < 255 || tmo_cycles > 256) begin
         n_errors++;
         $display("FAIL tmo.len: actual=%0d read cycles required=255..256", tmo_cycles);
      end
      chk("tmo.no_ack", 64'(tmo_acks), 64'h0);
      chk("tmo.err_set", 64'(timeout_err), 64'h1);
      chk("tmo.owner", 64'(owner), 64'h0);
      cyc();
      step(6'b001000); chk_state("tmo.idle", 0, 0, 2'b00, 4'b0000); cyc();
      step(6'b000010); chk_state("tmo.next", 1, 0, 2'b10, 4'b0010);
      chk("tmo.next_addr", 64'(address1), 64'h0080);
      chk("tmo.err_sticky", 64'(timeout_err), 64'h1); cyc();
      step(6'b000000); chk_state("tmo.done", 0, 0, 2'b00, 4'b0000); cyc();

      // reset in the 2nd cycle of a D write
      step(6'b000100); chk_state("rst.idle", 0, 0, 2'b00, 4'b0000); cyc();
      step(6'b000100); chk_state("rst.wr1", 0, 1, 2'b10, 4'b0000); cyc();
      Reset = 1'b1;
      step(6'b000000); chk_state("rst.wr2", 0, 1, 2'b10, 4'b0000); cyc();
      Reset = 1'b0;
      step(6'b000001); chk_state("rst.after", 0, 0, 2'b00, 4'b0000);
      chk("rst.address2", 64'(address2), 64'h0);
      chk("rst.data2", data2, 64'h0);
      chk("rst.timeout_err", 64'(timeout_err), 64'h0);

      // random phase: model starts from the post-reset IDLE state
      m_ph = 0; m_ph_prev = 0; m_g = 0; m_last = 1; m_wait = 0; m_err = 1'b0; m_rdf = 1'b0;
      m_ra = '0; m_wa = '0; m_line = '0;
      for (int r = 0; r < 2; r++) begin
         p_rd[r] = 1'b0; p_wr[r] = 1'b0; p_ra[r] = '0; p_wa[r] = '0; p_line[r] = '0;
         a_rd[r] = 1'b0; a_wr[r] = 1'b0; a_ra[r] = '0; a_wa[r] = '0; a_line[r] = '0;
         a_gap[r] = int'($urandom_range(0, 3));
      end
      p_rack = read_ack; p_wack = write_ack;
      mem_cnt = 0; mem_lat = 0;
      cyc();

      for (int t = 0; t < 3000; t++) begin
         // advance the model over the edge using what was driven last cycle
         case (m_ph)
            0: begin
               if (p_rd[0] | p_wr[0] | p_rd[1] | p_wr[1]) begin
                  if ((p_rd[0] | p_wr[0]) && (p_rd[1] | p_wr[1])) m_g = 1 - m_last;
                  else m_g = (p_rd[0] | p_wr[0]) ? 0 : 1;
                  m_rdf = p_rd[m_g]; m_ra = p_ra[m_g]; m_wa = p_wa[m_g]; m_line = p_line[m_g];
                  m_ph = p_wr[m_g] ? 1 : 2;
                  m_wait = 0;
               end
            end
            1: begin
               if (p_wack) begin m_ph = m_rdf ? 2 : 3; m_wait = 0; end
               else if (m_wait == 255) begin m_err = 1'b1; m_ph = 3; end
               else m_wait++;
            end
            2: begin
               if (p_rack) m_ph = 3;
               else if (m_wait == 255) begin m_err = 1'b1; m_ph = 3; end
               else m_wait++;
            end
            default: begin m_ph = 0; m_last = m_g; end
         endcase

         if (m_ph != m_ph_prev && (m_ph == 1 || m_ph == 2)) begin
            mem_cnt = 0;
            mem_lat = int'($urandom_range(0, 4));
         end
         read_ack  = ($urandom_range(0, 3) == 0);
         write_ack = ($urandom_range(0, 3) == 0);
         if (m_ph == 1) write_ack = (mem_cnt == mem_lat);
         if (m_ph == 2) read_ack  = (mem_cnt == mem_lat);
         data1 = {$urandom, $urandom};
         i_rd_req = a_rd[0]; i_wr_req = a_wr[0]; d_rd_req = a_rd[1]; d_wr_req = a_wr[1];
         i_rd_addr = a_ra[0]; i_wr_addr = a_wa[0]; d_rd_addr = a_ra[1]; d_wr_addr = a_wa[1];
         i_wr_line = a_line[0]; d_wr_line = a_line[1];
         for (int r = 0; r < 2; r++) begin
            p_rd[r] = a_rd[r]; p_wr[r] = a_wr[r];
            p_ra[r] = a_ra[r]; p_wa[r] = a_wa[r]; p_line[r] = a_line[r];
         end
         p_rack = read_ack; p_wack = write_ack;
         #1;

         e_acks = {(m_ph == 2) && (m_g == 0) && read_ack, (m_ph == 1) && (m_g == 0) && write_ack,
                   (m_ph == 2) && (m_g == 1) && read_ack, (m_ph == 1) && (m_g == 1) && write_ack};
         chk("rnd.owner", 64'(owner), (m_ph == 1 || m_ph == 2) ? 64'(m_g + 1) : 64'h0);
         chk("rnd.readM1", 64'(readM1), 64'(m_ph == 2));
         chk("rnd.writeM2", 64'(writeM2), 64'(m_ph == 1));
         chk("rnd.address1", 64'(address1), (m_ph == 2) ? 64'(m_ra) : 64'h0);
         chk("rnd.address2", 64'(address2), (m_ph == 1) ? 64'(m_wa) : 64'h0);
         chk("rnd.data2", data2, (m_ph == 1) ? m_line : 64'h0);
         chk("rnd.acks", 64'(acks_now()), 64'(e_acks));
         chk("rnd.timeout_err", 64'(timeout_err), 64'(m_err));
         if (e_acks[3] || e_acks[1]) chk("rnd.rd_line", rd_line, data1);

         if ((m_ph == 1 && !write_ack) || (m_ph == 2 && !read_ack)) mem_cnt++;
         m_ph_prev = m_ph;
         if (e_acks[3]) a_rd[0] = 1'b0;
         if (e_acks[2]) a_wr[0] = 1'b0;
         if (e_acks[1]) a_rd[1] = 1'b0;
         if (e_acks[0]) a_wr[1] = 1'b0;
         for (int r = 0; r < 2; r++) begin
            if (!a_rd[r] && !a_wr[r]) begin
               if (a_gap[r] == 0) begin
                  new_flags = 2'($urandom_range(1, 3));
                  a_rd[r] = new_flags[0];
                  a_wr[r] = new_flags[1];
                  a_ra[r] = 16'($urandom);
                  a_wa[r] = 16'($urandom);
                  a_line[r] = {$urandom, $urandom};
                  a_gap[r] = int'($urandom_range(0, 3));
               end else begin
                  a_gap[r]--;
               end
            end
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
